// File: rtl/ddr3_ui_sim_model.sv
// Behavioural DDR3 controller app_* interface with command/write-data FIFOs and fixed read latency.
// Optional random ready stalls are enabled by defining DDR3_SIM_RANDOM_STALL_EN.
module ddr3_ui_sim_model #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 28,
  parameter int unsigned MEM_AW       = 12,
  parameter int unsigned ADDR_SHIFT   = 3,
  parameter int unsigned BEATS_LOG2   = 1,
  parameter int unsigned CMD_FIFO_AW  = 2,
  parameter int unsigned WDF_AW       = 4,
  parameter int unsigned RD_LATENCY   = 4,
  parameter int unsigned INIT_CYCLES  = 50,
  parameter int unsigned MAINT_CYCLES = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ADDR_WIDTH-1:0]   i_app_addr,
  input  logic [2:0]              i_app_cmd,
  input  logic                    i_app_en,
  output logic                    o_app_rdy,
  input  logic [DATA_WIDTH-1:0]   i_app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] i_app_wdf_mask,
  input  logic                    i_app_wdf_wren,
  input  logic                    i_app_wdf_end,
  output logic                    o_app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   o_app_rd_data,
  output logic                    o_app_rd_data_valid,
  output logic                    o_app_rd_data_end,
  input  logic                    i_app_ref_req,
  output logic                    o_app_ref_ack,
  input  logic                    i_app_zq_req,
  output logic                    o_app_zq_ack,
  output logic                    o_init_calib_complete
);
  localparam int unsigned IW = MEM_AW - BEATS_LOG2;
  localparam int unsigned MW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {StInit, StIdle, StWrite, StRead, StMaint} state_e;

  state_e                  r_state;
  logic [31:0]             r_cnt;
  logic [IW-1:0]           r_idx;
  logic [BEATS_LOG2-1:0]   r_beat;
  logic                    r_ref_pend, r_zq_pend, r_maint_ref;
  logic [CMD_FIFO_AW:0]    r_cq_wp, r_cq_rp;
  logic [WDF_AW:0]         r_wdf_wp, r_wdf_rp;
  logic [IW:0]             r_cq [2**CMD_FIFO_AW];
  logic [DATA_WIDTH-1:0]   r_wdf_data [2**WDF_AW];
  logic [MW-1:0]           r_wdf_mask [2**WDF_AW];
  logic [DATA_WIDTH-1:0]   r_mem [2**MEM_AW];
  logic                    r_pv [RD_LATENCY];
  logic                    r_pe [RD_LATENCY];
  logic [DATA_WIDTH-1:0]   r_pd [RD_LATENCY];

  logic w_stall, w_cq_full, w_cq_empty, w_wdf_full, w_wdf_empty;
  logic w_cq_push, w_cq_pop, w_wdf_push, w_wr_beat, w_rd_beat, w_last, w_decide, w_maint_done;
  logic [IW:0]           w_cq_head;
  logic [MEM_AW-1:0]     w_word;
  logic                  w_unused;

`ifdef DDR3_SIM_RANDOM_STALL_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // wdf_end and upper address bits carry no information for this model
  assign w_unused = ^{i_app_wdf_end, i_app_addr};

  assign w_cq_empty  = (r_cq_wp == r_cq_rp);
  assign w_cq_full   = ((r_cq_wp ^ r_cq_rp) == {1'b1, {CMD_FIFO_AW{1'b0}}});
  assign w_wdf_empty = (r_wdf_wp == r_wdf_rp);
  assign w_wdf_full  = ((r_wdf_wp ^ r_wdf_rp) == {1'b1, {WDF_AW{1'b0}}});

  assign o_app_rdy     = o_init_calib_complete & ~w_cq_full & ~w_stall;
  assign o_app_wdf_rdy = o_init_calib_complete & ~w_wdf_full & ~w_stall;

  assign w_cq_push  = i_app_en & o_app_rdy & (i_app_cmd[2:1] == 2'b00);
  assign w_wdf_push = i_app_wdf_wren & o_app_wdf_rdy;
  assign w_cq_head  = r_cq[r_cq_rp[CMD_FIFO_AW-1:0]];

  assign w_wr_beat    = (r_state == StWrite) & ~w_wdf_empty;
  assign w_rd_beat    = (r_state == StRead);
  assign w_last       = &r_beat;
  assign w_word       = {r_idx, r_beat};
  // The last beat doubles as a dispatch slot so back-to-back commands leave no bubble
  assign w_decide     = (r_state == StIdle) | ((w_wr_beat | w_rd_beat) & w_last);
  assign w_cq_pop     = w_decide & ~(r_ref_pend | r_zq_pend) & ~w_cq_empty;
  assign w_maint_done = (r_state == StMaint) & (r_cnt == MAINT_CYCLES - 1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state               <= StInit;
      r_cnt                 <= '0;
      r_idx                 <= '0;
      r_beat                <= '0;
      r_maint_ref           <= 1'b0;
      o_init_calib_complete <= 1'b0;
      o_app_ref_ack         <= 1'b0;
      o_app_zq_ack          <= 1'b0;
    end else begin
      o_app_ref_ack <= 1'b0;
      o_app_zq_ack  <= 1'b0;
      unique case (r_state)
        StInit: begin
          if (r_cnt == INIT_CYCLES - 1) begin
            o_init_calib_complete <= 1'b1;
            r_state               <= StIdle;
            r_cnt                 <= '0;
          end else begin
            r_cnt <= r_cnt + 1;
          end
        end
        StMaint: begin
          if (w_maint_done) begin
            o_app_ref_ack <= r_maint_ref;
            o_app_zq_ack  <= ~r_maint_ref;
            r_state       <= StIdle;
          end else begin
            r_cnt <= r_cnt + 1;
          end
        end
        default: begin
          if (w_wr_beat | w_rd_beat) r_beat <= r_beat + 1'b1;
          if (w_decide) begin
            if (r_ref_pend | r_zq_pend) begin
              r_state     <= StMaint;
              r_cnt       <= '0;
              r_maint_ref <= r_ref_pend;
            end else if (!w_cq_empty) begin
              r_state <= w_cq_head[IW] ? StRead : StWrite;
              r_idx   <= w_cq_head[IW-1:0];
              r_beat  <= '0;
            end else begin
              r_state <= StIdle;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cq_wp    <= '0;
      r_cq_rp    <= '0;
      r_wdf_wp   <= '0;
      r_wdf_rp   <= '0;
      r_ref_pend <= 1'b0;
      r_zq_pend  <= 1'b0;
    end else begin
      if (w_cq_push)  r_cq_wp  <= r_cq_wp + 1'b1;
      if (w_cq_pop)   r_cq_rp  <= r_cq_rp + 1'b1;
      if (w_wdf_push) r_wdf_wp <= r_wdf_wp + 1'b1;
      if (w_wr_beat)  r_wdf_rp <= r_wdf_rp + 1'b1;
      r_ref_pend <= i_app_ref_req | (r_ref_pend & ~(w_maint_done & r_maint_ref));
      r_zq_pend  <= i_app_zq_req | (r_zq_pend & ~(w_maint_done & ~r_maint_ref));
    end
  end

  // Storage is never reset so memory contents survive a reset
  always_ff @(posedge i_clk) begin
    if (w_cq_push) r_cq[r_cq_wp[CMD_FIFO_AW-1:0]] <= {i_app_cmd == 3'b001, i_app_addr[ADDR_SHIFT +: IW]};
    if (w_wdf_push) begin
      r_wdf_data[r_wdf_wp[WDF_AW-1:0]] <= i_app_wdf_data;
      r_wdf_mask[r_wdf_wp[WDF_AW-1:0]] <= i_app_wdf_mask;
    end
    if (w_wr_beat) begin
      for (int b = 0; b < MW; b++) begin
        if (!r_wdf_mask[r_wdf_rp[WDF_AW-1:0]][b]) begin
          r_mem[w_word][8*b +: 8] <= r_wdf_data[r_wdf_rp[WDF_AW-1:0]][8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pe[i] <= 1'b0;
        r_pd[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_rd_beat;
      r_pe[0] <= w_rd_beat & w_last;
      r_pd[0] <= r_mem[w_word];
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  assign o_app_rd_data       = r_pd[RD_LATENCY-1];
  assign o_app_rd_data_valid = r_pv[RD_LATENCY-1];
  assign o_app_rd_data_end   = r_pe[RD_LATENCY-1];
endmodule

// File: tb/tb_ddr3_ui_sim_model.sv
// Scoreboard bench for ddr3_ui_sim_model: a byte-level memory model predicts every read beat.
module tb_ddr3_ui_sim_model;
  localparam int RD_LATENCY = 4;
  localparam int INIT_CYCLES = 50;
  localparam int MAINT_CYCLES = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [27:0] app_addr = '0;
  logic [2:0]  app_cmd = '0;
  logic        app_en = 1'b0, app_rdy;
  logic [31:0] wdf_data = '0;
  logic [3:0]  wdf_mask = '0;
  logic        wdf_wren = 1'b0, wdf_end = 1'b0, wdf_rdy;
  logic [31:0] rd_data;
  logic        rd_valid, rd_end;
  logic        ref_req = 1'b0, ref_ack, zq_req = 1'b0, zq_ack, calib;

  always #5 clk = ~clk;

  ddr3_ui_sim_model dut (
    .i_clk(clk), .i_rst(rst), .i_app_addr(app_addr), .i_app_cmd(app_cmd), .i_app_en(app_en),
    .o_app_rdy(app_rdy), .i_app_wdf_data(wdf_data), .i_app_wdf_mask(wdf_mask),
    .i_app_wdf_wren(wdf_wren), .i_app_wdf_end(wdf_end), .o_app_wdf_rdy(wdf_rdy),
    .o_app_rd_data(rd_data), .o_app_rd_data_valid(rd_valid), .o_app_rd_data_end(rd_end),
    .i_app_ref_req(ref_req), .o_app_ref_ack(ref_ack), .i_app_zq_req(zq_req),
    .o_app_zq_ack(zq_ack), .o_init_calib_complete(calib)
  );

  typedef struct packed {logic [31:0] d; logic e;} exp_t;

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        q_exp[$];
  logic [31:0] m_mem [int];
  int          q_wcmd[$];
  logic [31:0] q_wdat[$];
  logic [3:0]  q_wmsk[$];

  // Word index = addr[3 +: 11] * 2 + beat; mask bit i protects byte i
  function automatic void model_apply();
    while (q_wcmd.size() > 0 && q_wdat.size() >= 2) begin
      int base = ((q_wcmd.pop_front() >> 3) & 'h7FF) * 2;
      for (int b = 0; b < 2; b++) begin
        logic [31:0] d = q_wdat.pop_front();
        logic [3:0]  m = q_wmsk.pop_front();
        logic [31:0] w = m_mem.exists(base + b) ? m_mem[base + b] : 32'h0;
        for (int k = 0; k < 4; k++) if (!m[k]) w[8*k +: 8] = d[8*k +: 8];
        m_mem[base + b] = w;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      exp_t e;
      n_vec++;
      if (q_exp.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: got data=%h end=%b, required no beat", rd_data, rd_end);
      end else begin
        e = q_exp.pop_front();
        if ({rd_data, rd_end} !== {e.d, e.e}) begin
          n_err++;
          $display("FAIL rd_beat: got data=%h end=%b, required data=%h end=%b",
                   rd_data, rd_end, e.d, e.e);
        end
      end
    end
  end

  task automatic send_cmd(input logic [2:0] c, input int a);
    bit ok = 0;
    @(negedge clk);
    app_en = 1'b1; app_cmd = c; app_addr = 28'(a);
    for (int i = 0; i < 200; i++) begin
      if (app_rdy) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk); #1;
      if (c == 3'b000) begin
        q_wcmd.push_back(a);
        model_apply();
      end else if (c == 3'b001) begin
        for (int b = 0; b < 2; b++) begin
          exp_t e;
          e.d = m_mem[((a >> 3) & 'h7FF) * 2 + b];
          e.e = (b == 1);
          q_exp.push_back(e);
        end
      end
    end else begin
      n_vec++; n_err++;
      $display("FAIL cmd_accept_timeout: got app_rdy=0 for 200 cycles, required 1");
    end
    app_en = 1'b0;
  endtask

  task automatic send_data(input logic [31:0] d, input logic [3:0] m);
    bit ok = 0;
    @(negedge clk);
    wdf_wren = 1'b1; wdf_data = d; wdf_mask = m;
    for (int i = 0; i < 200; i++) begin
      if (wdf_rdy) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk); #1;
      q_wdat.push_back(d); q_wmsk.push_back(m);
      model_apply();
    end else begin
      n_vec++; n_err++;
      $display("FAIL wdf_accept_timeout: got app_wdf_rdy=0 for 200 cycles, required 1");
    end
    wdf_wren = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && q_exp.size() != 0; i++) @(negedge clk);
    n_vec++;
    if (q_exp.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, q_exp.size());
    end
  endtask

  task automatic test_init();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= INIT_CYCLES; k++) begin
      logic exp = (k >= INIT_CYCLES);
      @(negedge clk);
      n_vec++;
      if (calib !== exp || app_rdy !== exp || wdf_rdy !== exp) begin
        n_err++;
        $display("FAIL init_cycle_%0d: got calib=%b rdy=%b wdf_rdy=%b, required %b",
                 k, calib, app_rdy, wdf_rdy, exp);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({rd_valid, rd_end, rd_data, app_rdy, wdf_rdy, ref_ack, zq_ack, calib} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b end=%b data=%h rdy=%b wdf_rdy=%b acks=%b%b calib=%b, required all 0",
               rd_valid, rd_end, rd_data, app_rdy, wdf_rdy, ref_ack, zq_ack, calib);
    end
    test_init();
  endtask

  task automatic test_write_read();
    int lat = -1;
    send_cmd(3'b000, 'h10);
    send_data(32'hDEADBEEF, 4'h0);
    send_data(32'h01234567, 4'h0);
    repeat (6) @(negedge clk);
    send_cmd(3'b001, 'h10);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rd_valid) begin lat = k - 1; break; end
    end
    // one cycle to dispatch the command from the queue, then the fixed pipeline
    n_vec++;
    if (lat != RD_LATENCY + 1) begin
      n_err++;
      $display("FAIL read_latency: got %0d cycles, required %0d", lat, RD_LATENCY + 1);
    end
    wait_drain("write_read");
  endtask

  task automatic test_mask();
    send_cmd(3'b000, 'h20);
    send_data(32'hFFFFFFFF, 4'h0);
    send_data(32'hFFFFFFFF, 4'h0);
    send_cmd(3'b000, 'h20);
    send_data(32'h00000000, 4'b0101);
    send_data(32'h00000000, 4'b1111);
    send_cmd(3'b001, 'h20);
    wait_drain("mask");
  endtask

  task automatic test_backpressure();
    bit rec = 0;
    for (int i = 0; i < 5; i++) send_cmd(3'b000, 'h40 + i * 8);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if (app_rdy !== 1'b0) begin
        n_err++;
        $display("FAIL cmd_fifo_full_cycle_%0d: got app_rdy=%b, required 0", c, app_rdy);
      end
    end
    for (int i = 0; i < 10; i++) send_data(32'hA5000000 + i, 4'h0);
    for (int k = 0; k < 40 && !rec; k++) begin
      @(negedge clk);
      rec = app_rdy;
    end
    n_vec++;
    if (!rec) begin
      n_err++;
      $display("FAIL cmd_fifo_recover: got app_rdy=0, required 1");
    end
    for (int i = 0; i < 5; i++) send_cmd(3'b001, 'h40 + i * 8);
    wait_drain("backpressure");
  endtask

  task automatic test_back_to_back();
    int run = 0;
    bit seen = 0;
    send_cmd(3'b001, 'h10);
    send_cmd(3'b001, 'h20);
    send_cmd(3'b001, 'h48);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rd_valid) begin seen = 1; run++; end
      else if (seen) break;
    end
    n_vec++;
    if (run != 6) begin
      n_err++;
      $display("FAIL back_to_back_run: got %0d consecutive valid beats, required 6", run);
    end
    wait_drain("back_to_back");
  endtask

  task automatic test_refresh();
    int acks = 0, zacks = 0, last_v = -1, maxgap = 0;
    repeat (4) @(negedge clk);
    send_cmd(3'b001, 'h10);
    ref_req = 1'b1;
    send_cmd(3'b001, 'h20);
    ref_req = 1'b0;
    send_cmd(3'b001, 'h40);
    send_cmd(3'b001, 'h50);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ref_ack) acks++;
      if (zq_ack) zacks++;
      if (rd_valid) begin
        if (last_v >= 0 && k - last_v - 1 > maxgap) maxgap = k - last_v - 1;
        last_v = k;
      end
    end
    n_vec++;
    if (acks != 1 || zacks != 0) begin
      n_err++;
      $display("FAIL refresh_ack: got ref_ack cycles=%0d zq_ack cycles=%0d, required 1 and 0",
               acks, zacks);
    end
    n_vec++;
    if (maxgap < MAINT_CYCLES) begin
      n_err++;
      $display("FAIL refresh_pause: got read gap %0d cycles, required >= %0d", maxgap, MAINT_CYCLES);
    end
    wait_drain("refresh");
  endtask

  task automatic test_maint_both();
    int rn = 0, zn = 0, rt = -1, zt = -1;
    @(negedge clk); ref_req = 1'b1; zq_req = 1'b1;
    @(negedge clk); ref_req = 1'b0; zq_req = 1'b0;
    @(negedge clk); ref_req = 1'b1;
    @(negedge clk); ref_req = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ref_ack) begin rn++; if (rt < 0) rt = k; end
      if (zq_ack) begin zn++; if (zt < 0) zt = k; end
    end
    n_vec++;
    if (rn != 1 || zn != 1) begin
      n_err++;
      $display("FAIL maint_ack_count: got ref=%0d zq=%0d, required 1 and 1", rn, zn);
    end
    n_vec++;
    if (!(rt >= 0 && zt - rt > MAINT_CYCLES)) begin
      n_err++;
      $display("FAIL maint_order: got ref_ack at %0d zq_ack at %0d, required ref first then zq >%0d later",
               rt, zt, MAINT_CYCLES);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    send_cmd(3'b001, 'h20);
    send_cmd(3'b001, 'h40);
    send_cmd(3'b001, 'h48);
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      seen = rd_valid;
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (!seen || {rd_valid, rd_end, app_rdy, wdf_rdy, calib} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_mid_burst: got seen=%b valid=%b end=%b rdy=%b wdf_rdy=%b calib=%b, required seen=1 rest 0",
               seen, rd_valid, rd_end, app_rdy, wdf_rdy, calib);
    end
    q_exp.delete();
    q_wcmd.delete(); q_wdat.delete(); q_wmsk.delete();
    test_init();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_vec++;
      if (rd_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flushed_fifo_beat: got valid=%b, required 0", rd_valid);
      end
    end
    send_cmd(3'b001, 'h10);
    wait_drain("after_reset");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_mask();
    test_backpressure();
    test_back_to_back();
    test_refresh();
    test_maint_both();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
